fifo_stream_reader: RTL

Read-side consumer for the synchronous BRAM-backed FIFO. Pops words from the FIFO's RD/EMPTY/DATA_RD port, absorbs the one-cycle BRAM read latency in a 2-entry output buffer, and presents the data as a valid/ready stream with a LAST marker every `burst_len` words. Sits between the FIFO and any downstream stream sink, sharing the FIFO's clock.

---
 rtl/fifo_stream_reader.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the BRAM-backed FIFO: pops words, absorbs the
// one-cycle read latency in a 2-entry buffer and emits a valid/ready stream.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   ENABLE              permits new FIFO reads
//   FIFO_EMPTY          FIFO empty flag
//   FIFO_DATA           FIFO read data, valid the cycle after FIFO_RD
//   FIFO_RD             FIFO read strobe (combinational)
//   M_VALID/M_DATA      stream output, head of the buffer
//   M_LAST              final word of a burst of burst_len words
//   M_READY             downstream accept
//   BUSY                read in flight or buffer non-empty
//   WORD_CNT            words delivered since reset, wrapping
module fifo_stream_reader #(
    parameter int length     = 16,
    parameter int burst_len  = 8,
    parameter int cnt_length = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  FIFO_EMPTY,
    input  logic [length-1:0]     FIFO_DATA,
    output logic                  FIFO_RD,
    output logic                  M_VALID,
    output logic [length-1:0]     M_DATA,
    output logic                  M_LAST,
    input  logic                  M_READY,
    output logic                  BUSY,
    output logic [cnt_length-1:0] WORD_CNT
);

    localparam logic [cnt_length-1:0] BEAT_MAX = cnt_length'(burst_len - 1);

    logic                  inflight;
    logic [1:0]            occ;
    logic [cnt_length-1:0] beat;
    logic [length-1:0]     buf_data [2];
    logic                  buf_last [2];

    logic       pop;
    logic [2:0] level;
    logic [1:0] occ_left;
    logic       tail;
    logic       cap_last;

    always_comb begin
        pop      = (occ != 2'd0) && M_READY;
        // words committed to the buffer once this cycle's pop is taken
        level    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        FIFO_RD  = !RESET && ENABLE && !FIFO_EMPTY && (level < 3'd2);
        // a captured word lands behind whatever survives this cycle's pop
        occ_left = occ - {1'b0, pop};
        tail     = occ_left[0];
        cap_last = (beat == BEAT_MAX);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inflight    <= 1'b0;
            occ         <= 2'd0;
            beat        <= '0;
            WORD_CNT    <= '0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            inflight <= FIFO_RD;
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_last[0] <= buf_last[1];
                WORD_CNT    <= WORD_CNT + 1'b1;
            end
            // later assignment wins when the capture targets entry 0
            if (inflight) begin
                buf_data[tail] <= FIFO_DATA;
                buf_last[tail] <= cap_last;
                beat           <= cap_last ? '0 : beat + 1'b1;
            end
        end
    end

    always_comb begin
        M_VALID = (occ != 2'd0);
        M_DATA  = buf_data[0];
        M_LAST  = buf_last[0] && M_VALID;
        BUSY    = inflight || M_VALID;
    end

endmodule
